// File: rtl/patch_cfg_pkg.sv
// Shared register map, FSM encoding and descriptor layout for the patch
// config sequencer. patch_store and the host software headers use the
// same addresses.
package patch_cfg_pkg;

   localparam int DEF_ADDR_W  = 23;
   localparam int DEF_IDX_W   = 6;
   localparam int DEF_OFF_W   = 13;
   localparam int DEF_HOLDOFF = 16;
   localparam int HOLD_CNT_W  = 8;    // holds HOLDOFF up to 255

   localparam logic [15:0] CAM_ADDR_LO  = 16'h7000;
   localparam logic [15:0] CAM_ADDR_HI  = 16'h7001;
   localparam logic [15:0] CAM_MASK_LO  = 16'h7002;
   localparam logic [15:0] CAM_MASK_HI  = 16'h7003;
   localparam logic [15:0] CAM_INDEX    = 16'h7004;
   localparam logic [15:0] OFFSET_BASE  = 16'h7800;
   localparam logic [15:0] CONTENT_BASE = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE, ST_A_LO, ST_A_HI, ST_M_LO, ST_M_HI, ST_OFS, ST_TRIG, ST_HOLD
   } seq_state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_ADDR_W-1:0] mask;
      logic [DEF_IDX_W-1:0]  index;
      logic [DEF_OFF_W-1:0]  offset;
   } patch_desc_t;

   // CAM staging registers: a host write here mid-sequence may corrupt them
   function automatic logic is_cam_reg(input logic [15:0] a);
      return (a >= CAM_ADDR_LO) && (a <= CAM_INDEX);
   endfunction

endpackage

// File: rtl/patch_cfg_sequencer_mux.sv
// cfg_bus_mux: registered two-input priority mux onto the config bus.
// Host always wins; the sequencer gets a same-cycle grant when the host
// is idle so its FSM can advance.
//  mclk, reset            clock, async active-high reset
//  i_host_strobe/addr/data host write (no backpressure)
//  i_seq_req/addr/data     pending sequencer write
//  o_seq_grant             sequencer write taken this cycle
//  o_cfg_strobe/addr/data  registered merged bus
module cfg_bus_mux (
   input  logic        mclk,
   input  logic        reset,
   input  logic        i_host_strobe,
   input  logic [15:0] i_host_addr,
   input  logic [15:0] i_host_data,
   input  logic        i_seq_req,
   input  logic [15:0] i_seq_addr,
   input  logic [15:0] i_seq_data,
   output logic        o_seq_grant,
   output logic        o_cfg_strobe,
   output logic [15:0] o_cfg_addr,
   output logic [15:0] o_cfg_data
);

   assign o_seq_grant = i_seq_req & ~i_host_strobe;

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         o_cfg_strobe <= 1'b0;
         o_cfg_addr   <= '0;
         o_cfg_data   <= '0;
      end else if (i_host_strobe) begin
         o_cfg_strobe <= 1'b1;
         o_cfg_addr   <= i_host_addr;
         o_cfg_data   <= i_host_data;
      end else if (i_seq_req) begin
         o_cfg_strobe <= 1'b1;
         o_cfg_addr   <= i_seq_addr;
         o_cfg_data   <= i_seq_data;
      end else begin
         o_cfg_strobe <= 1'b0;
      end
   end

endmodule

// File: rtl/patch_cfg_sequencer.sv
// patch_cfg_sequencer: expands one patch descriptor into the ordered CAM
// programming writes (addr lo/hi, mask lo/hi, slot offset, trigger), merges
// them behind host config writes, then waits out the CAM write holdoff.
//  mclk, reset                  clock, async active-high reset
//  i_host_addr/data/strobe      host config write
//  i_desc_valid, o_desc_ready   descriptor handshake
//  i_desc_addr/mask/index/offset descriptor fields (sampled on accept only)
//  o_cfg_addr/data/strobe       merged config bus
//  o_seq_busy                   sequence or holdoff in progress
//  o_conflict, i_conflict_clr   sticky host-hit-CAM-staging flag and clear
module patch_cfg_sequencer
   import patch_cfg_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int OFF_W   = DEF_OFF_W,
   parameter int HOLDOFF = DEF_HOLDOFF
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic [15:0]       i_host_addr,
   input  logic [15:0]       i_host_data,
   input  logic              i_host_strobe,
   input  logic              i_desc_valid,
   output logic              o_desc_ready,
   input  logic [ADDR_W-1:0] i_desc_addr,
   input  logic [ADDR_W-1:0] i_desc_mask,
   input  logic [IDX_W-1:0]  i_desc_index,
   input  logic [OFF_W-1:0]  i_desc_offset,
   output logic [15:0]       o_cfg_addr,
   output logic [15:0]       o_cfg_data,
   output logic              o_cfg_strobe,
   output logic              o_seq_busy,
   output logic              o_conflict,
   input  logic              i_conflict_clr
);

   seq_state_t            r_state;
   logic [ADDR_W-1:0]     r_addr;
   logic [ADDR_W-1:0]     r_mask;
   logic [IDX_W-1:0]      r_index;
   logic [OFF_W-1:0]      r_offset;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic                  r_conflict;

   logic                  w_seq_req;
   logic [15:0]           w_seq_addr;
   logic [15:0]           w_seq_data;
   logic                  w_grant;
   logic                  w_conflict_set;

   assign o_seq_busy     = (r_state != ST_IDLE);
   assign o_desc_ready   = (r_state == ST_IDLE) && !reset;
   assign o_conflict     = r_conflict;
   assign w_conflict_set = i_host_strobe && is_cam_reg(i_host_addr) && o_seq_busy;

   // Write presented by the current state; upper halves zero-extended
   always_comb begin
      w_seq_req  = 1'b1;
      w_seq_addr = '0;
      w_seq_data = '0;
      case (r_state)
         ST_A_LO: begin w_seq_addr = CAM_ADDR_LO; w_seq_data = r_addr[15:0];      end
         ST_A_HI: begin w_seq_addr = CAM_ADDR_HI; w_seq_data = 16'(r_addr >> 16); end
         ST_M_LO: begin w_seq_addr = CAM_MASK_LO; w_seq_data = r_mask[15:0];      end
         ST_M_HI: begin w_seq_addr = CAM_MASK_HI; w_seq_data = 16'(r_mask >> 16); end
         ST_OFS:  begin w_seq_addr = OFFSET_BASE + 16'(r_index); w_seq_data = 16'(r_offset); end
         ST_TRIG: begin w_seq_addr = CAM_INDEX;   w_seq_data = 16'(r_index);      end
         default: w_seq_req = 1'b0;
      endcase
   end

   cfg_bus_mux u_mux (
      .mclk          (mclk),
      .reset         (reset),
      .i_host_strobe (i_host_strobe),
      .i_host_addr   (i_host_addr),
      .i_host_data   (i_host_data),
      .i_seq_req     (w_seq_req),
      .i_seq_addr    (w_seq_addr),
      .i_seq_data    (w_seq_data),
      .o_seq_grant   (w_grant),
      .o_cfg_strobe  (o_cfg_strobe),
      .o_cfg_addr    (o_cfg_addr),
      .o_cfg_data    (o_cfg_data)
   );

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_mask     <= '0;
         r_index    <= '0;
         r_offset   <= '0;
         r_hold_cnt <= '0;
         r_conflict <= 1'b0;
      end else begin
         // set has priority over clear
         r_conflict <= w_conflict_set | (r_conflict & ~i_conflict_clr);
         case (r_state)
            ST_IDLE: if (i_desc_valid) begin
               r_addr   <= i_desc_addr;
               r_mask   <= i_desc_mask;
               r_index  <= i_desc_index;
               r_offset <= i_desc_offset;
               r_state  <= ST_A_LO;
            end
            ST_A_LO: if (w_grant) r_state <= ST_A_HI;
            ST_A_HI: if (w_grant) r_state <= ST_M_LO;
            ST_M_LO: if (w_grant) r_state <= ST_M_HI;
            ST_M_HI: if (w_grant) r_state <= ST_OFS;
            ST_OFS:  if (w_grant) r_state <= ST_TRIG;
            ST_TRIG: if (w_grant) begin
               r_state    <= ST_HOLD;
               r_hold_cnt <= HOLD_CNT_W'(HOLDOFF);
            end
            ST_HOLD: begin
               // HOLDOFF cycles in HOLD, so ready returns HOLDOFF cycles after the trigger strobe
               r_hold_cnt <= r_hold_cnt - 1'b1;
               if (r_hold_cnt == HOLD_CNT_W'(1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_patch_cfg_sequencer.sv
module tb_patch_cfg_sequencer;
   import patch_cfg_pkg::*;

   logic        mclk = 1'b0;
   logic        reset;
   logic [15:0] i_host_addr, i_host_data;
   logic        i_host_strobe;
   logic        i_desc_valid;
   logic        o_desc_ready;
   logic [22:0] i_desc_addr, i_desc_mask;
   logic [5:0]  i_desc_index;
   logic [12:0] i_desc_offset;
   logic [15:0] o_cfg_addr, o_cfg_data;
   logic        o_cfg_strobe, o_seq_busy, o_conflict, i_conflict_clr;

   int npass = 0;
   int ntot  = 0;

   patch_cfg_sequencer dut (
      .mclk(mclk), .reset(reset),
      .i_host_addr(i_host_addr), .i_host_data(i_host_data), .i_host_strobe(i_host_strobe),
      .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
      .i_desc_addr(i_desc_addr), .i_desc_mask(i_desc_mask),
      .i_desc_index(i_desc_index), .i_desc_offset(i_desc_offset),
      .o_cfg_addr(o_cfg_addr), .o_cfg_data(o_cfg_data), .o_cfg_strobe(o_cfg_strobe),
      .o_seq_busy(o_seq_busy), .o_conflict(o_conflict), .i_conflict_clr(i_conflict_clr)
   );

   always #5 mclk = ~mclk;

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) begin
         npass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one bus write expected after the next edge
   task automatic expw(input string tag, input logic [15:0] a, input logic [15:0] d);
      tick();
      chk(tag, {31'd0, o_cfg_strobe, o_cfg_addr, o_cfg_data}, {31'd0, 1'b1, a, d});
   endtask

   // n cycles after the trigger strobe: quiet and not ready until the n-th
   task automatic hold_chk(input string tag, input int n);
      logic bad;
      bad = 1'b0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (i < n && (o_desc_ready || o_cfg_strobe)) bad = 1'b1;
      end
      chk({tag, "_quiet"}, {63'd0, bad}, 64'd0);
      chk({tag, "_ready"}, {62'd0, o_desc_ready, o_cfg_strobe}, 64'd2);
   endtask

   task automatic set_desc(input logic [22:0] a, input logic [22:0] m,
                           input logic [5:0] ix, input logic [12:0] of);
      i_desc_addr = a; i_desc_mask = m; i_desc_index = ix; i_desc_offset = of;
   endtask

   task automatic host(input logic s, input logic [15:0] a, input logic [15:0] d);
      i_host_strobe = s; i_host_addr = a; i_host_data = d;
   endtask

   initial begin
      logic seen;
      reset = 1'b1; i_desc_valid = 1'b0; i_conflict_clr = 1'b0;
      host(1'b0, 16'h0, 16'h0);
      set_desc(23'h0, 23'h0, 6'h0, 13'h0);

      // 1. reset
      repeat (3) tick();
      chk("rst_outs", {o_desc_ready, o_cfg_strobe, o_cfg_addr, o_cfg_data, o_seq_busy, o_conflict}, 0);
      reset = 1'b0;
      #1;
      chk("rst_rel_ready", {62'd0, o_desc_ready, o_cfg_strobe}, 64'd2);
      tick();
      chk("post_rst", {62'd0, o_desc_ready, o_cfg_strobe}, 64'd2);

      // 2. plain sequence
      set_desc(23'h12_3456, 23'h00_000F, 6'd5, 13'h0100);
      i_desc_valid = 1'b1;
      tick();
      i_desc_valid = 1'b0;
      chk("t2_accept", {61'd0, o_desc_ready, o_seq_busy, o_cfg_strobe}, 64'b010);
      expw("t2_alo", 16'h7000, 16'h3456);
      expw("t2_ahi", 16'h7001, 16'h0012);
      expw("t2_mlo", 16'h7002, 16'h000F);
      expw("t2_mhi", 16'h7003, 16'h0000);
      expw("t2_ofs", 16'h7805, 16'h0100);
      expw("t2_trg", 16'h7004, 16'h0005);
      hold_chk("t2_hold", 16);

      // 3. host write pre-empts the 7001 issue
      set_desc(23'h7A_BCDE, 23'h01_0203, 6'h2A, 13'h1FFF);
      i_desc_valid = 1'b1;
      tick();
      i_desc_valid = 1'b0;
      expw("t3_alo", 16'h7000, 16'hBCDE);
      host(1'b1, CONTENT_BASE, 16'hBEEF);
      expw("t3_host", 16'h8000, 16'hBEEF);
      host(1'b0, 16'h0, 16'h0);
      expw("t3_ahi", 16'h7001, 16'h007A);
      expw("t3_mlo", 16'h7002, 16'h0203);
      expw("t3_mhi", 16'h7003, 16'h0001);
      expw("t3_ofs", 16'h782A, 16'h1FFF);
      expw("t3_trg", 16'h7004, 16'h002A);
      chk("t3_noconf", {63'd0, o_conflict}, 64'd0);
      hold_chk("t3_hold", 16);

      // CAM register write while idle is not a conflict
      host(1'b1, 16'h7003, 16'h0A0A);
      expw("idle_host", 16'h7003, 16'h0A0A);
      host(1'b0, 16'h0, 16'h0);
      chk("idle_noconf", {63'd0, o_conflict}, 64'd0);

      // 4. conflict flag
      set_desc(23'h00_0000, 23'h7F_FFFF, 6'd63, 13'h0000);
      i_desc_valid = 1'b1;
      tick();
      i_desc_valid = 1'b0;
      host(1'b1, 16'h7002, 16'h1234);
      expw("t4_host", 16'h7002, 16'h1234);
      host(1'b0, 16'h0, 16'h0);
      chk("t4_conf_set", {63'd0, o_conflict}, 64'd1);
      expw("t4_alo", 16'h7000, 16'h0000);
      i_conflict_clr = 1'b1;
      expw("t4_ahi", 16'h7001, 16'h0000);
      chk("t4_conf_clr", {63'd0, o_conflict}, 64'd0);
      host(1'b1, 16'h7004, 16'h5555);
      expw("t4_host2", 16'h7004, 16'h5555);
      host(1'b0, 16'h0, 16'h0);
      i_conflict_clr = 1'b0;
      chk("t4_set_wins", {63'd0, o_conflict}, 64'd1);
      expw("t4_mlo", 16'h7002, 16'hFFFF);
      expw("t4_mhi", 16'h7003, 16'h007F);
      expw("t4_ofs", 16'h783F, 16'h0000);
      expw("t4_trg", 16'h7004, 16'h003F);
      hold_chk("t4_hold", 16);
      chk("t4_sticky", {63'd0, o_conflict}, 64'd1);
      i_conflict_clr = 1'b1;
      tick();
      i_conflict_clr = 1'b0;
      chk("t4_clr_idle", {63'd0, o_conflict}, 64'd0);

      // 5. back-to-back descriptors, fields changed mid-sequence
      set_desc(23'h00_1111, 23'h00_0000, 6'd1, 13'h0011);
      i_desc_valid = 1'b1;
      tick();
      set_desc(23'h00_2222, 23'h00_0001, 6'd2, 13'h0022);
      expw("t5a_alo", 16'h7000, 16'h1111);
      expw("t5a_ahi", 16'h7001, 16'h0000);
      expw("t5a_mlo", 16'h7002, 16'h0000);
      expw("t5a_mhi", 16'h7003, 16'h0000);
      expw("t5a_ofs", 16'h7801, 16'h0011);
      expw("t5a_trg", 16'h7004, 16'h0001);
      hold_chk("t5a_hold", 16);
      tick();
      i_desc_valid = 1'b0;
      chk("t5b_accept", {61'd0, o_desc_ready, o_seq_busy, o_cfg_strobe}, 64'b010);
      expw("t5b_alo", 16'h7000, 16'h2222);
      expw("t5b_ahi", 16'h7001, 16'h0000);
      expw("t5b_mlo", 16'h7002, 16'h0001);
      expw("t5b_mhi", 16'h7003, 16'h0000);
      expw("t5b_ofs", 16'h7802, 16'h0022);
      expw("t5b_trg", 16'h7004, 16'h0002);
      hold_chk("t5b_hold", 16);

      // 6. reset during M_HI
      set_desc(23'h55_AAAA, 23'h2A_5555, 6'd9, 13'h0ABC);
      i_desc_valid = 1'b1;
      tick();
      i_desc_valid = 1'b0;
      expw("t6_alo", 16'h7000, 16'hAAAA);
      expw("t6_ahi", 16'h7001, 16'h0055);
      expw("t6_mlo", 16'h7002, 16'h5555);
      reset = 1'b1;
      #1;
      chk("t6_rst_outs", {o_desc_ready, o_cfg_strobe, o_cfg_addr, o_cfg_data, o_seq_busy, o_conflict}, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("t6_rel_ready", {62'd0, o_desc_ready, o_seq_busy}, 64'd2);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_cfg_strobe || !o_desc_ready) seen = 1'b1;
      end
      chk("t6_no_replay", {63'd0, seen}, 64'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
